// File: rtl/lynx_kbd_pkg.sv
// Shared keyboard types: decoder states, PS/2 prefix codes and the
// PS/2 set-2 to Lynx 48 matrix lookup table.
package lynx_kbd_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} kbd_state_t;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_EE = 8'hEE;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } key_loc_t;

    function automatic key_loc_t key_at(input int r, input int c);
        key_at.hit = 1'b1;
        key_at.row = 4'(r);
        key_at.col = 3'(c);
    endfunction

    // Keyboard housekeeping bytes (self-test, ack, resend, echo, pause)
    function automatic logic is_ignored(input logic [7:0] code);
        return code inside {SC_E1, SC_AA, SC_FA, SC_FE, SC_EE};
    endfunction

    function automatic key_loc_t map_key(input logic ext, input logic [7:0] code);
        map_key = '0;
        case ({ext, code})
            9'h016: map_key = key_at(0, 0);  // 1
            9'h012: map_key = key_at(0, 1);  // LShift
            9'h059: map_key = key_at(0, 1);  // RShift shares the bit
            9'h014: map_key = key_at(0, 2);  // LCtrl
            9'h076: map_key = key_at(0, 3);  // Esc
            9'h058: map_key = key_at(0, 4);  // Caps
            9'h01E: map_key = key_at(1, 0);  // 2
            9'h026: map_key = key_at(1, 1);  // 3
            9'h015: map_key = key_at(1, 2);  // Q
            9'h01D: map_key = key_at(1, 3);  // W
            9'h024: map_key = key_at(1, 4);  // E
            9'h022: map_key = key_at(1, 5);  // X
            9'h01A: map_key = key_at(1, 6);  // Z
            9'h01C: map_key = key_at(2, 0);  // A
            9'h01B: map_key = key_at(2, 1);  // S
            9'h023: map_key = key_at(2, 2);  // D
            9'h021: map_key = key_at(2, 3);  // C
            9'h025: map_key = key_at(2, 4);  // 4
            9'h02D: map_key = key_at(2, 5);  // R
            9'h02E: map_key = key_at(3, 0);  // 5
            9'h034: map_key = key_at(3, 1);  // G
            9'h02B: map_key = key_at(3, 2);  // F
            9'h02A: map_key = key_at(3, 3);  // V
            9'h02C: map_key = key_at(3, 4);  // T
            9'h036: map_key = key_at(4, 0);  // 6
            9'h033: map_key = key_at(4, 1);  // H
            9'h035: map_key = key_at(4, 2);  // Y
            9'h032: map_key = key_at(4, 3);  // B
            9'h031: map_key = key_at(4, 4);  // N
            9'h03D: map_key = key_at(5, 0);  // 7
            9'h03E: map_key = key_at(5, 1);  // 8
            9'h03B: map_key = key_at(5, 2);  // J
            9'h03C: map_key = key_at(5, 3);  // U
            9'h03A: map_key = key_at(5, 4);  // M
            9'h046: map_key = key_at(6, 0);  // 9
            9'h043: map_key = key_at(6, 1);  // I
            9'h042: map_key = key_at(6, 2);  // K
            9'h041: map_key = key_at(6, 3);  // ,
            9'h045: map_key = key_at(7, 0);  // 0
            9'h044: map_key = key_at(7, 1);  // O
            9'h04B: map_key = key_at(7, 2);  // L
            9'h049: map_key = key_at(7, 3);  // .
            9'h04D: map_key = key_at(7, 4);  // P
            9'h04E: map_key = key_at(8, 0);  // -
            9'h04C: map_key = key_at(8, 1);  // ;
            9'h04A: map_key = key_at(8, 2);  // /
            9'h052: map_key = key_at(8, 3);  // '
            9'h054: map_key = key_at(8, 4);  // [
            9'h05B: map_key = key_at(8, 5);  // ]
            9'h029: map_key = key_at(9, 0);  // Space
            9'h066: map_key = key_at(9, 1);  // Backspace
            9'h175: map_key = key_at(9, 2);  // Up
            9'h05A: map_key = key_at(9, 3);  // Return
            9'h15A: map_key = key_at(9, 3);  // Keypad Enter
            9'h172: map_key = key_at(9, 4);  // Down
            9'h16B: map_key = key_at(9, 5);  // Left
            9'h174: map_key = key_at(9, 6);  // Right
            default: ;
        endcase
    endfunction

endpackage

// File: rtl/lynx_ps2_keymatrix_if.sv
// PS/2 input, CPU row select and keyboard status outputs of the keymatrix.
interface lynx_ps2_keymatrix_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] row;
    logic [7:0] col_n;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    modport master (output ps2_clk, ps2_data, row,
                    input  col_n, scan_valid, scan_code, frame_err);
    modport slave  (input  ps2_clk, ps2_data, row,
                    output col_n, scan_valid, scan_code, frame_err);
endinterface

// File: rtl/lynx_ps2_rx.sv
// PS/2 receiver: synchronise, deglitch the clock, shift in 11-bit frames,
// check start/parity/stop, and drop partial frames after a silence timeout.
module lynx_ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] flt_cnt;
    logic          clk_flt;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    sh;
    logic [TW-1:0] to_cnt;

    // Falling edge is the cycle the filter commits to low, so data is taken immediately.
    assign fall = clk_flt && !clk_sync[1] && (flt_cnt == FLT_LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            flt_cnt  <= '0;
            clk_flt  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_flt <= clk_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            sh         <= '0;
            to_cnt     <= '0;
            scan_valid <= 1'b0;
            scan_code  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    // sh[0]=start, sh[8:1]=data, sh[9]=parity; current bit is stop
                    if (!sh[0] && (^sh[9:1]) && dat_sync[1]) begin
                        scan_code  <= sh[8:1];
                        scan_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    sh[bit_cnt] <= dat_sync[1];
                    bit_cnt     <= bit_cnt + 1'b1;
                end
            end else begin
                if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
                if (bit_cnt != 4'd0 && to_cnt == TO_MAX) begin
                    bit_cnt   <= '0;
                    frame_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/lynx_ps2_keymatrix.sv
// PS/2 to Lynx 48 keyboard matrix: prefix decoder, 10x8 pressed-key matrix
// and the registered active-low column byte for the CPU-selected row.
module lynx_ps2_keymatrix
    import lynx_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int ROWS       = 10
) (
    input  logic clk_sys,
    input  logic reset,
    lynx_ps2_keymatrix_if.slave bus
);
    localparam logic [4:0] ROWS_W = 5'(ROWS);

    logic                  sv, fe;
    logic [7:0]            sc;
    kbd_state_t            state, state_nxt;
    logic                  ext_sel, upd, make;
    key_loc_t              loc;
    logic [ROWS-1:0][7:0]  matrix;
    logic [7:0]            col_n_q;

    lynx_ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .scan_valid(sv),
        .scan_code (sc),
        .frame_err (fe)
    );

    assign bus.scan_valid = sv;
    assign bus.scan_code  = sc;
    assign bus.frame_err  = fe;
    assign bus.col_n      = col_n_q;

    assign ext_sel = (state == ST_EXT) || (state == ST_EXTBRK);
    assign loc     = map_key(ext_sel, sc);

    always_comb begin
        state_nxt = state;
        upd       = 1'b0;
        make      = 1'b0;
        if (sv) begin
            case (state)
                ST_IDLE: begin
                    if (sc == SC_E0)           state_nxt = ST_EXT;
                    else if (sc == SC_F0)      state_nxt = ST_BRK;
                    else if (!is_ignored(sc)) begin upd = 1'b1; make = 1'b1; end
                end
                ST_EXT: begin
                    // Repeated E0 keeps waiting for the real extended code
                    if (sc == SC_F0)           state_nxt = ST_EXTBRK;
                    else if (sc != SC_E0) begin
                        upd = 1'b1; make = 1'b1; state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (sc == SC_E0)           state_nxt = ST_EXTBRK;
                    else begin upd = 1'b1; state_nxt = ST_IDLE; end
                end
                default: begin upd = 1'b1; state_nxt = ST_IDLE; end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            matrix  <= '0;
            col_n_q <= 8'hFF;
        end else begin
            state <= state_nxt;
            if (upd && loc.hit && ({1'b0, loc.row} < ROWS_W))
                matrix[loc.row][loc.col] <= make;
            col_n_q <= ({1'b0, bus.row} < ROWS_W) ? ~matrix[bus.row] : 8'hFF;
        end
    end
endmodule
